// File: rtl/rgb_pwm_fader_if.sv
// Command port of the RGB PWM fader.
// Valid/ready handshake carrying channel select, target duty and fade rate.
interface rgb_pwm_fader_if #(
    parameter int unsigned RAMP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_chan;
    logic [7:0]        cmd_duty;
    logic [RAMP_W-1:0] cmd_fade;

    modport master (
        output cmd_valid,
        output cmd_chan,
        output cmd_duty,
        output cmd_fade,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_chan,
        input  cmd_duty,
        input  cmd_fade,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Three-channel 8-bit PWM generator with per-channel linear duty fading.
// Duty changes take effect only on PWM period boundaries, so every period is whole.
module rgb_pwm_fader #(
    parameter int unsigned PRESCALE = 188,
    parameter int unsigned RAMP_W   = 8
) (
    input  logic           clk,
    input  logic           resetn,
    rgb_pwm_fader_if.slave cmd,
    output logic           pwm_r,
    output logic           pwm_g,
    output logic           pwm_b,
    output logic           busy
);
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RAMP
    } state_e;

    logic [PS_W-1:0] presc_q;
    logic [PS_W-1:0] presc_d;
    logic [7:0]      phase_q;
    logic [7:0]      phase_d;
    logic            tick;
    logic            boundary;
    logic            accept;
    logic [2:0]      pwm_vec;
    logic [2:0]      ramp_vec;

    assign tick     = (presc_q == PS_MAX);
    assign boundary = tick && (phase_q == 8'hFF);
    assign presc_d  = tick ? '0 : presc_q + 1'b1;
    assign phase_d  = tick ? phase_q + 8'd1 : phase_q;

    // Commands are refused on the boundary so accept and duty update never collide.
    assign cmd.cmd_ready = resetn && !boundary;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
            phase_q <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        state_e            state_q;
        logic [7:0]        cur_q;
        logic [7:0]        cur_d;
        logic [7:0]        tgt_q;
        logic [RAMP_W-1:0] rate_q;
        logic [RAMP_W-1:0] step_q;
        logic              hit;
        logic              step_due;
        logic              pwm_q;

        assign hit = accept &&
                     (cmd.cmd_chan == 2'd3 || cmd.cmd_chan == 2'(i));
        assign step_due = (step_q == rate_q - 1'b1);

        always_comb begin
            cur_d = cur_q;
            if (boundary && state_q == RAMP) begin
                if (rate_q == '0) begin
                    cur_d = tgt_q;
                end else if (step_due) begin
                    cur_d = (tgt_q > cur_q) ? cur_q + 8'd1 : cur_q - 8'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q <= IDLE;
                cur_q   <= '0;
                tgt_q   <= '0;
                rate_q  <= '0;
                step_q  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                cur_q <= cur_d;
                // Compare next-state values so pwm lines up with the phase it reflects.
                pwm_q <= (phase_d < cur_d);
                unique case (1'b1)
                    hit: begin
                        tgt_q   <= cmd.cmd_duty;
                        rate_q  <= cmd.cmd_fade;
                        step_q  <= '0;
                        state_q <= (cmd.cmd_duty != cur_q) ? RAMP : IDLE;
                    end
                    (boundary && state_q == RAMP): begin
                        if (rate_q == '0) begin
                            state_q <= IDLE;
                        end else if (step_due) begin
                            step_q <= '0;
                            if (cur_d == tgt_q) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign pwm_vec[i]  = pwm_q;
        assign ramp_vec[i] = (state_q == RAMP);
    end

    assign pwm_r = pwm_vec[0];
    assign pwm_g = pwm_vec[1];
    assign pwm_b = pwm_vec[2];
    assign busy  = |ramp_vec;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader with PRESCALE=1 (one phase step per clk).
// A period-level reference model predicts every output each cycle.
module tb_rgb_pwm_fader;
    logic clk = 1'b0;
    logic resetn;
    logic pwm_r;
    logic pwm_g;
    logic pwm_b;
    logic busy;

    rgb_pwm_fader_if #(.RAMP_W(8)) cif ();

    rgb_pwm_fader #(
        .PRESCALE(1),
        .RAMP_W  (8)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .cmd   (cif),
        .pwm_r (pwm_r),
        .pwm_g (pwm_g),
        .pwm_b (pwm_b),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef logic [4:0] exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int ph;
    int mcur[3];
    int mtgt[3];
    int mrate[3];
    int mcnt[3];
    bit last_acc;
    int hs = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // One clock cycle: predict outputs, then advance the model across the edge.
    task automatic cyc();
        exp_t e;
        bit   rdy;
        bit   bz;
        rdy = (resetn === 1'b1) && (ph != 255);
        bz  = 1'b0;
        for (int i = 0; i < 3; i++) bz |= (mcur[i] != mtgt[i]);
        e = {mcur[0] > ph, mcur[1] > ph, mcur[2] > ph, bz, rdy};
        q.push_back(e);
        #2;
        if (cif.cmd_valid === 1'b1 && cif.cmd_ready === 1'b1) hs++;
        last_acc = rdy && (cif.cmd_valid === 1'b1);
        if (resetn !== 1'b1) begin
            ph = 0;
            for (int i = 0; i < 3; i++) begin
                mcur[i] = 0; mtgt[i] = 0; mrate[i] = 0; mcnt[i] = 0;
            end
        end else begin
            if (ph == 255) begin
                for (int i = 0; i < 3; i++) begin
                    if (mcur[i] != mtgt[i]) begin
                        if (mrate[i] == 0) begin
                            mcur[i] = mtgt[i];
                        end else begin
                            mcnt[i]++;
                            if (mcnt[i] >= mrate[i]) begin
                                mcur[i] += (mtgt[i] > mcur[i]) ? 1 : -1;
                                mcnt[i] = 0;
                            end
                        end
                    end
                end
            end
            if (last_acc) begin
                for (int i = 0; i < 3; i++) begin
                    if (cif.cmd_chan == 2'd3 || int'(cif.cmd_chan) == i) begin
                        mtgt[i]  = int'(cif.cmd_duty);
                        mrate[i] = int'(cif.cmd_fade);
                        mcnt[i]  = 0;
                    end
                end
            end
            ph = (ph + 1) % 256;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        run(n);
        resetn = 1'b1;
    endtask

    task automatic issue(input logic [1:0] ch, input logic [7:0] d,
                         input logic [7:0] f, output int waits);
        cif.cmd_valid = 1'b1;
        cif.cmd_chan  = ch;
        cif.cmd_duty  = d;
        cif.cmd_fade  = f;
        waits = 0;
        cyc();
        while (!last_acc && waits < 4) begin
            waits++;
            cyc();
        end
        check("accept_timeout", {31'd0, last_acc}, 32'd1);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic period_count(output int r, output int g, output int b);
        for (int k = 0; k < 256 && ph != 0; k++) cyc();
        r = 0; g = 0; b = 0;
        for (int k = 0; k < 256; k++) begin
            r += (pwm_r === 1'b1) ? 1 : 0;
            g += (pwm_g === 1'b1) ? 1 : 0;
            b += (pwm_b === 1'b1) ? 1 : 0;
            cyc();
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {pwm_r, pwm_g, pwm_b, busy, cif.cmd_ready};
                total++;
                if (got !== e) begin
                    bad++;
                    if (bad < 30)
                        $display("FAIL scoreboard t=%0t got=%b want=%b (r g b busy ready)",
                                 $time, got, e);
                end
            end
        end
    end

    initial begin : stim
        int w;
        int r;
        int g;
        int b;
        int h0;
        resetn        = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_chan  = 2'd0;
        cif.cmd_duty  = 8'd0;
        cif.cmd_fade  = 8'd0;
        ph = 0;
        for (int i = 0; i < 3; i++) begin
            mcur[i] = 0; mtgt[i] = 0; mrate[i] = 0; mcnt[i] = 0;
        end
        @(negedge clk);
        run(3);
        check("rst_outputs", {28'd0, pwm_r, pwm_g, pwm_b, busy}, 32'd0);
        check("rst_ready", {31'd0, cif.cmd_ready}, 32'd0);
        resetn = 1'b1;
        run(5);

        issue(2'd0, 8'd64, 8'd0, w);
        period_count(r, g, b);
        check("red64_r", r, 64);
        check("red64_g", g, 0);
        check("red64_b", b, 0);

        issue(2'd3, 8'd255, 8'd0, w);
        period_count(r, g, b);
        check("all255_r", r, 255);
        check("all255_g", g, 255);
        check("all255_b", b, 255);

        do_reset(1);
        run(10);
        issue(2'd1, 8'd4, 8'd2, w);
        check("fade_busy_hi", {31'd0, busy}, 32'd1);
        run(10 * 256);
        period_count(r, g, b);
        check("fade_g4", g, 4);
        check("fade_busy_lo", {31'd0, busy}, 32'd0);

        issue(2'd2, 8'd200, 8'd1, w);
        for (int k = 0; k < 60 * 256 && mcur[2] != 50; k++) cyc();
        issue(2'd2, 8'd10, 8'd1, w);
        run(45 * 256);
        period_count(r, g, b);
        check("retarget_b10", b, 10);

        for (int k = 0; k < 256 && ph != 255; k++) cyc();
        h0 = hs;
        issue(2'd0, 8'd100, 8'd0, w);
        check("boundary_refused", w, 1);
        run(3);
        check("handshakes", hs - h0, 1);

        issue(2'd0, 8'd255, 8'd3, w);
        run(5 * 256);
        do_reset(1);
        check("midramp_rst_out", {28'd0, pwm_r, pwm_g, pwm_b, busy}, 32'd0);
        run(300);
        issue(2'd0, 8'd1, 8'd0, w);
        period_count(r, g, b);
        check("post_rst_r1", r, 1);

        repeat (40) begin
            if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 3)));
            issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 3)), w);
            run(int'($urandom_range(0, 700)));
        end
        run(600);

        #2;
        check("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
